// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine: result = base^exponent mod modulus.
// Uses constant-time right-to-left square-and-multiply with bit-serial interleaved modular multiplication.
module rsa_modexp_core #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned EXP_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 ready,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);

  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [IW-1:0] I_LAST = IW'(EXP_WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_R, r_B, r_n, r_acc1, r_acc2, r_result;
  logic [EXP_WIDTH-1:0] r_E;
  logic [KW-1:0]        r_k;
  logic [IW-1:0]        r_i;
  logic                 r_ready, r_done, r_error;

  logic                 w_bbit;
  logic [WIDTH-1:0]     w_p1, w_p2, w_r_next;

  // One interleaved step: acc = (2*acc + bit*other) mod n. Accumulators stay below n,
  // so they are stored in WIDTH bits while the step itself works in WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] other,
                                               input logic             b_bit,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH:0] t, nn;
    nn = {1'b0, n};
    t  = {acc, 1'b0};
    if (t >= nn) t = t - nn;
    if (b_bit) t = t + {1'b0, other};
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    w_bbit   = r_B[K_LAST - r_k];
    w_p1     = mm_step(r_acc1, r_R, w_bbit, r_n);
    w_p2     = mm_step(r_acc2, r_B, w_bbit, r_n);
    w_r_next = r_E[0] ? w_p1 : r_R;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_R      <= '0;
      r_B      <= '0;
      r_n      <= '0;
      r_E      <= '0;
      r_acc1   <= '0;
      r_acc2   <= '0;
      r_k      <= '0;
      r_i      <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if ((modulus < WIDTH'(2)) || (base >= modulus)) begin
              r_done   <= 1'b1;
              r_error  <= 1'b1;
              r_result <= '0;
            end else begin
              r_R     <= WIDTH'(1);
              r_B     <= base;
              r_E     <= exponent;
              r_n     <= modulus;
              r_acc1  <= '0;
              r_acc2  <= '0;
              r_k     <= '0;
              r_i     <= '0;
              r_ready <= 1'b0;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_k == K_LAST) begin
            // Both products are always committed, so timing never depends on the exponent.
            r_R    <= w_r_next;
            r_B    <= w_p2;
            r_E    <= r_E >> 1;
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_k    <= '0;
            r_i    <= r_i + IW'(1);
            if (r_i == I_LAST) begin
              r_result <= w_r_next;
              r_done   <= 1'b1;
              r_error  <= 1'b0;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end
          end else begin
            r_acc1 <= w_p1;
            r_acc2 <= w_p2;
            r_k    <= r_k + KW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign error  = r_error;
  assign result = r_result;

endmodule
